// File: rtl/wb_arbiter_pkg.sv
// Shared widths, producer indices, slot payload type and pointer helper for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NSRC = 3;
  localparam int unsigned PTRW = 2;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_LSU = 1;
  localparam int unsigned SRC_MDU = 2;

  // One held result: destination register plus data.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Pointer after a grant: one past the winner, wrapping 2 -> 0; holds when nothing granted.
  function automatic logic [PTRW-1:0] rr_after(input logic [NSRC-1:0] grant,
                                               input logic [PTRW-1:0] cur);
    logic [PTRW-1:0] nxt;
    nxt = cur;
    if (grant[SRC_ALU]) nxt = PTRW'(SRC_LSU);
    if (grant[SRC_LSU]) nxt = PTRW'(SRC_MDU);
    if (grant[SRC_MDU]) nxt = PTRW'(SRC_ALU);
    return nxt;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational 3-way round-robin picker: first full slot at or after rr_ptr wins.
module wb_rr_pick
  import wb_arbiter_pkg::*;
(
  input  logic [NSRC-1:0] full,
  input  logic [PTRW-1:0] rr_ptr,
  output logic [NSRC-1:0] grant_c,
  output logic            any_grant_c
);

  // Rotated priority search; pointer value 3 is unreachable and treated as 0.
  always_comb begin
    grant_c = '0;
    case (rr_ptr)
      2'd1: begin
        if      (full[1]) grant_c[1] = 1'b1;
        else if (full[2]) grant_c[2] = 1'b1;
        else if (full[0]) grant_c[0] = 1'b1;
      end
      2'd2: begin
        if      (full[2]) grant_c[2] = 1'b1;
        else if (full[0]) grant_c[0] = 1'b1;
        else if (full[1]) grant_c[1] = 1'b1;
      end
      default: begin
        if      (full[0]) grant_c[0] = 1'b1;
        else if (full[1]) grant_c[1] = 1'b1;
        else if (full[2]) grant_c[2] = 1'b1;
      end
    endcase
  end

  assign any_grant_c = |grant_c;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three one-entry producer slots drained round-robin into one registered RF write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*AW-1:0]   src_rd,
  input  logic [NSRC*DW-1:0]   src_data,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  output logic                 busy
);

  wb_entry_t       slot     [NSRC];
  wb_entry_t       in_entry [NSRC];
  wb_entry_t       win;
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] accept;
  logic            any_grant;
  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] rr_ptr_nxt;

  // Round-robin choice among currently held results (new arrivals are not visible yet).
  wb_rr_pick u_pick (
    .full        (full),
    .rr_ptr      (rr_ptr),
    .grant_c     (grant),
    .any_grant_c (any_grant)
  );

  // Split the flat producer buses into per-slot payloads.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      in_entry[i].rd   = src_rd[i*AW +: AW];
      in_entry[i].data = src_data[i*DW +: DW];
    end
  end

  // A slot accepts when empty or draining this cycle; nothing is accepted during reset.
  always_comb begin
    src_ready = '0;
    accept    = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = ~rst & (~full[i] | grant[i]);
      accept[i]    = src_valid[i] & src_ready[i];
    end
  end

  // Select the granted slot's payload for the write port (grant is one-hot).
  always_comb begin
    win = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) win = slot[i];
    end
  end

  // Next arbitration pointer.
  always_comb begin
    rr_ptr_nxt = rr_after(grant, rr_ptr);
  end

  // Slot storage: a reload with rd!=0 wins over the drain; rd==0 results are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (accept[i] && (in_entry[i].rd != '0)) begin
          full[i] <= 1'b1;
          slot[i] <= in_entry[i];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Registered RF write port and round-robin pointer; address/data hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      rr_ptr <= '0;
    end else begin
      we     <= any_grant;
      rr_ptr <= rr_ptr_nxt;
      if (any_grant) begin
        waddr <= win.rd;
        wdata <= win.data;
      end
    end
  end

  assign busy = (|full) | we;

endmodule
